// File: rtl/mdp3_word_packer.sv
// ---------------------------------------------------------------------------
// mdp3_word_packer
//   Packs a framed byte stream (one MDP3 message per in_valid..in_last frame)
//   MSB-first into 64-bit MESSAGE words for the MDP3 parser. The first byte of
//   each word lands in MESSAGE[63:56]; a short final word is zero-padded in
//   its low bytes. Messages longer than MAX_MSG_BYTES are cut at that length,
//   the cut word is flagged with msg_err, and the rest of the frame is
//   swallowed.
//
// Ports
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   in_valid/in_data/in_last/in_ready
//                   byte input; a byte is taken when in_valid && in_ready
//   MESSAGE         packed word (registered)
//   message_ready   MESSAGE and sideband valid (registered)
//   out_ready       downstream takes the word when message_ready && out_ready
//   msg_start       word holds byte 0 of the message
//   msg_last        word is the final word of the message
//   last_bytes      valid bytes in the word (1..8)
//   msg_err         message truncated at MAX_MSG_BYTES (only with msg_last)
// ---------------------------------------------------------------------------
module mdp3_word_packer #(
  parameter int MAX_MSG_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic [63:0] MESSAGE,
  output logic        message_ready,
  input  logic        out_ready,
  output logic        msg_start,
  output logic        msg_last,
  output logic [3:0]  last_bytes,
  output logic        msg_err
);

  localparam int               CNT_W   = $clog2(MAX_MSG_BYTES + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_MSG_BYTES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DROP    = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [63:0]        acc_q, acc_d;
  logic [2:0]         idx_q, idx_d;
  logic [CNT_W-1:0]   msg_cnt_q, msg_cnt_d;
  logic               start_pend_q, start_pend_d;
  logic [63:0]        message_q, message_d;
  logic               message_ready_q, message_ready_d;
  logic               msg_start_q, msg_start_d;
  logic               msg_last_q, msg_last_d;
  logic [3:0]         last_bytes_q, last_bytes_d;
  logic               msg_err_q, msg_err_d;

  logic               in_ready_s;
  logic               accept_s;
  logic [63:0]        acc_new_s;
  logic [CNT_W-1:0]   cnt_inc_s;
  logic               at_max_s;
  logic               word_done_s;
  logic               msg_end_s;
  logic               trunc_s;

  // Next-state, datapath and output-register load logic.
  always_comb begin
    state_d         = state_q;
    acc_d           = acc_q;
    idx_d           = idx_q;
    msg_cnt_d       = msg_cnt_q;
    start_pend_d    = start_pend_q;
    message_d       = message_q;
    message_ready_d = message_ready_q;
    msg_start_d     = msg_start_q;
    msg_last_d      = msg_last_q;
    last_bytes_d    = last_bytes_q;
    msg_err_d       = msg_err_q;

    // DROP never issues words, so it can always sink bytes.
    if (state_q == S_DROP) begin
      in_ready_s = 1'b1;
    end else begin
      in_ready_s = !message_ready_q || out_ready;
    end
    accept_s = in_valid && in_ready_s;

    // acc is zero below the current slot, so OR-ing the shifted byte in is
    // equivalent to writing acc[63-8*idx -: 8].
    acc_new_s   = acc_q | ({in_data, 56'd0} >> {idx_q, 3'b000});
    cnt_inc_s   = msg_cnt_q + CNT_W'(1);
    at_max_s    = (cnt_inc_s == MAX_CNT);
    word_done_s = (idx_q == 3'd7) || in_last || at_max_s;
    msg_end_s   = in_last || at_max_s;
    trunc_s     = at_max_s && !in_last;

    // A handshake retires the word; a load below in the same cycle overrides.
    if (message_ready_q && out_ready) begin
      message_ready_d = 1'b0;
    end else begin
      message_ready_d = message_ready_q;
    end

    case (state_q)
      S_IDLE, S_COLLECT: begin
        if (accept_s) begin
          if (word_done_s) begin
            message_d       = acc_new_s;
            message_ready_d = 1'b1;
            msg_start_d     = (state_q == S_IDLE) || start_pend_q;
            msg_last_d      = msg_end_s;
            last_bytes_d    = {1'b0, idx_q} + 4'd1;
            msg_err_d       = trunc_s;
            acc_d           = 64'd0;
            idx_d           = 3'd0;
            start_pend_d    = 1'b0;
          end else begin
            acc_d        = acc_new_s;
            idx_d        = idx_q + 3'd1;
            start_pend_d = start_pend_q || (state_q == S_IDLE);
          end
          if (msg_end_s) begin
            msg_cnt_d = {CNT_W{1'b0}};
            state_d   = trunc_s ? S_DROP : S_IDLE;
          end else begin
            msg_cnt_d = cnt_inc_s;
            state_d   = S_COLLECT;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_DROP: begin
        if (accept_s && in_last) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DROP;
        end
      end
      default: begin
        state_d      = S_IDLE;
        acc_d        = 64'd0;
        idx_d        = 3'd0;
        msg_cnt_d    = {CNT_W{1'b0}};
        start_pend_d = 1'b0;
      end
    endcase
  end

  // State, accumulator and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      acc_q           <= 64'd0;
      idx_q           <= 3'd0;
      msg_cnt_q       <= {CNT_W{1'b0}};
      start_pend_q    <= 1'b0;
      message_q       <= 64'd0;
      message_ready_q <= 1'b0;
      msg_start_q     <= 1'b0;
      msg_last_q      <= 1'b0;
      last_bytes_q    <= 4'd0;
      msg_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      acc_q           <= acc_d;
      idx_q           <= idx_d;
      msg_cnt_q       <= msg_cnt_d;
      start_pend_q    <= start_pend_d;
      message_q       <= message_d;
      message_ready_q <= message_ready_d;
      msg_start_q     <= msg_start_d;
      msg_last_q      <= msg_last_d;
      last_bytes_q    <= last_bytes_d;
      msg_err_q       <= msg_err_d;
    end
  end

  assign in_ready      = in_ready_s;
  assign MESSAGE       = message_q;
  assign message_ready = message_ready_q;
  assign msg_start     = msg_start_q;
  assign msg_last      = msg_last_q;
  assign last_bytes    = last_bytes_q;
  assign msg_err       = msg_err_q;

endmodule
